// File: rtl/bus_pkg.sv
// Shared types and constants for the two-master bus arbiter.
package bus_pkg;

   localparam int ADDR_W_DEF = 16;
   localparam int DATA_W_DEF = 16;

   // Address regions, taken from the top two address bits.
   localparam logic [1:0] REG_IO  = 2'd0;
   localparam logic [1:0] REG_RAM = 2'd1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_ACK
   } bus_state_t;

   // One-hot chip select for a region number.
   function automatic logic [3:0] region_cs(input logic [1:0] region);
      return 4'b0001 << region;
   endfunction

endpackage

// File: rtl/bus_rr_pick.sv
// Winner selection for two masters: lock owner first, then round-robin.
module bus_rr_pick (
   input  logic [1:0] req,
   input  logic       last_gnt,
   input  logic       lock_vld,
   input  logic       lock_own,
   input  logic       burst_hit,
   output logic       win_vld,
   output logic       win
);

   // Single requester wins; on a tie the lock owner wins unless its burst is spent.
   always_comb begin
      win_vld = |req;
      win     = 1'b0;
      case (req)
         2'b01:   win = 1'b0;
         2'b10:   win = 1'b1;
         2'b11:   win = (lock_vld && !burst_hit) ? lock_own : ~last_gnt;
         default: win = 1'b0;
      endcase
   end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master, single-slave bus arbiter with lock bursts and region decode.
module bus_arbiter
   import bus_pkg::*;
#(
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int DATA_W    = DATA_W_DEF,
   parameter int BURST_MAX = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              m0_req,
   input  logic              m0_lock,
   input  logic              m0_write,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_gnt,
   output logic              m0_ack,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_req,
   input  logic              m1_lock,
   input  logic              m1_write,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_gnt,
   output logic              m1_ack,
   output logic [DATA_W-1:0] m1_rdata,
   output logic [ADDR_W-1:0] s_addr,
   output logic [DATA_W-1:0] s_wdata,
   output logic              s_write,
   output logic [3:0]        s_cs,
   input  logic [DATA_W-1:0] s_rdata_io,
   input  logic [DATA_W-1:0] s_rdata_ram,
   output logic              bus_err
);

   localparam int CNT_W = $clog2(BURST_MAX + 1);

   bus_state_t        state, state_nxt;
   logic              cur;
   logic              last_gnt;
   logic              lock_vld;
   logic              lock_own;
   logic              err_q;
   logic [CNT_W-1:0]  burst_cnt;
   logic [1:0]        req;
   logic              win_vld;
   logic              win;
   logic              burst_hit;
   logic              sel_write;
   logic              sel_lock;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic [DATA_W-1:0] rd_mux;
   logic [1:0]        region;

   assign req       = {m1_req, m0_req};
   assign burst_hit = (burst_cnt >= CNT_W'(BURST_MAX));

   bus_rr_pick u_pick (
      .req       (req),
      .last_gnt  (last_gnt),
      .lock_vld  (lock_vld),
      .lock_own  (lock_own),
      .burst_hit (burst_hit),
      .win_vld   (win_vld),
      .win       (win)
   );

   // Route the granted master's request fields and decode its region.
   always_comb begin
      sel_write = cur ? m1_write : m0_write;
      sel_lock  = cur ? m1_lock  : m0_lock;
      sel_addr  = cur ? m1_addr  : m0_addr;
      sel_wdata = cur ? m1_wdata : m0_wdata;
      region    = sel_addr[ADDR_W-1 -: 2];
      case (region)
         REG_IO:  rd_mux = s_rdata_io;
         REG_RAM: rd_mux = s_rdata_ram;
         default: rd_mux = '0;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Next state: every transfer is IDLE -> ACCESS -> ACK -> IDLE.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (win_vld) state_nxt = ST_ACCESS;
         ST_ACCESS: state_nxt = ST_ACK;
         ST_ACK:    state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // Master and slave outputs decoded from state and current owner.
   always_comb begin
      m0_gnt  = (state != ST_IDLE) && !cur;
      m1_gnt  = (state != ST_IDLE) &&  cur;
      m0_ack  = (state == ST_ACK)  && !cur;
      m1_ack  = (state == ST_ACK)  &&  cur;
      bus_err = (state == ST_ACK)  && err_q;
      s_addr  = '0;
      s_wdata = '0;
      s_write = 1'b0;
      s_cs    = '0;
      if (state == ST_ACCESS) begin
         s_addr  = sel_addr;
         s_wdata = sel_wdata;
         s_write = sel_write;
         s_cs    = region_cs(region);
      end
   end

   // Arbitration bookkeeping, read-data capture and lock tracking.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cur       <= 1'b0;
         last_gnt  <= 1'b1;
         lock_vld  <= 1'b0;
         lock_own  <= 1'b0;
         burst_cnt <= '0;
         err_q     <= 1'b0;
         m0_rdata  <= '0;
         m1_rdata  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (lock_vld && !req[lock_own]) lock_vld <= 1'b0;
               if (win_vld) begin
                  cur      <= win;
                  last_gnt <= win;
                  // Count run length of grants to the same master, saturating.
                  if (win == last_gnt) begin
                     if (!burst_hit) burst_cnt <= burst_cnt + CNT_W'(1);
                  end else begin
                     burst_cnt <= CNT_W'(1);
                  end
               end
            end
            ST_ACCESS: begin
               err_q <= region[1];
               if (!sel_write) begin
                  if (cur) m1_rdata <= rd_mux;
                  else     m0_rdata <= rd_mux;
               end
            end
            ST_ACK: begin
               lock_vld <= sel_lock;
               lock_own <= cur;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized self-checking bench for bus_arbiter against a transaction-level model.
module tb_bus_arbiter;

   localparam int AW = 16;
   localparam int DW = 16;
   localparam int BM = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          m0_req, m0_lock, m0_write, m1_req, m1_lock, m1_write;
   logic [AW-1:0] m0_addr, m1_addr, s_addr;
   logic [DW-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, s_wdata;
   logic [DW-1:0] s_rdata_io, s_rdata_ram;
   logic          m0_gnt, m0_ack, m1_gnt, m1_ack, s_write, bus_err;
   logic [3:0]    s_cs;

   always #5 clk = ~clk;

   bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_MAX(BM)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_req(m0_req), .m0_lock(m0_lock), .m0_write(m0_write), .m0_addr(m0_addr),
      .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_lock(m1_lock), .m1_write(m1_write), .m1_addr(m1_addr),
      .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
      .s_addr(s_addr), .s_wdata(s_wdata), .s_write(s_write), .s_cs(s_cs),
      .s_rdata_io(s_rdata_io), .s_rdata_ram(s_rdata_ram), .bus_err(bus_err)
   );

   typedef struct packed {
      logic        wr;
      logic [15:0] addr;
      logic [15:0] data;
      logic        lock;
      logic        drop;
   } txn_t;

   txn_t q0[$];
   txn_t q1[$];
   int   n_chk = 0;
   int   n_bad = 0;
   int   acks[$];

   // Reference model: phase of the current transfer, winner history, lock status.
   int          busy = 0;
   int          w = 0;
   int          last = 1;
   int          run = 0;
   bit          lock_live = 0;
   bit          exp_err = 0;
   int          done_m = -1;
   bit          rd_fix = 0;
   txn_t        cur_t;
   logic [15:0] exp_rd [2];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic txn_t mk(input logic wr, input logic [15:0] a, input logic [15:0] d,
                               input logic lk, input logic dr);
      txn_t t;
      t.wr = wr; t.addr = a; t.data = d; t.lock = lk; t.drop = dr;
      return t;
   endfunction

   task automatic step();
      txn_t        h;
      logic [1:0]  reqv;
      logic [1:0]  rg;
      logic [3:0]  ecs;
      int          nw;
      // master behaviour: retire a transfer the cycle after its ack
      if (done_m == 0 && q0.size() > 0) void'(q0.pop_front());
      if (done_m == 1 && q1.size() > 0) void'(q1.pop_front());
      done_m = -1;
      if (q0.size() > 0) begin
         h = q0[0];
         m0_req = !(busy != 0 && w == 0 && h.drop);
         m0_write = h.wr; m0_addr = h.addr; m0_wdata = h.data; m0_lock = h.lock;
      end else m0_req = 1'b0;
      if (q1.size() > 0) begin
         h = q1[0];
         m1_req = !(busy != 0 && w == 1 && h.drop);
         m1_write = h.wr; m1_addr = h.addr; m1_wdata = h.data; m1_lock = h.lock;
      end else m1_req = 1'b0;
      if (!rd_fix) begin
         s_rdata_io  = 16'($urandom);
         s_rdata_ram = 16'($urandom);
      end
      // model transition for the coming edge
      reqv = {m1_req, m0_req};
      if (!rst_n) begin
         busy = 0; last = 1; run = 0; lock_live = 0; exp_err = 0;
         exp_rd[0] = '0; exp_rd[1] = '0; done_m = -1;
      end else begin
         case (busy)
            0: begin
               if (lock_live && !reqv[last]) lock_live = 0;
               if (reqv != 2'b00) begin
                  if (reqv == 2'b11) nw = (lock_live && run < BM) ? last : 1 - last;
                  else               nw = reqv[1] ? 1 : 0;
                  run  = (nw == last) ? run + 1 : 1;
                  last = nw;
                  w    = nw;
                  cur_t = (nw == 1) ? q1[0] : q0[0];
                  busy = 2;
               end
            end
            2: begin
               rg = cur_t.addr[15:14];
               exp_err = (rg >= 2);
               if (!cur_t.wr) exp_rd[w] = (rg == 0) ? s_rdata_io : (rg == 1) ? s_rdata_ram : 16'h0000;
               busy = 1;
            end
            default: begin
               lock_live = cur_t.lock;
               done_m = w;
               busy = 0;
            end
         endcase
      end
      @(posedge clk);
      @(negedge clk);
      ecs = (busy == 2) ? (4'b0001 << cur_t.addr[15:14]) : 4'b0000;
      check_val("m0_gnt",   m0_gnt,   busy != 0 && w == 0);
      check_val("m1_gnt",   m1_gnt,   busy != 0 && w == 1);
      check_val("m0_ack",   m0_ack,   busy == 1 && w == 0);
      check_val("m1_ack",   m1_ack,   busy == 1 && w == 1);
      check_val("s_cs",     s_cs,     ecs);
      check_val("s_write",  s_write,  busy == 2 && cur_t.wr);
      check_val("s_addr",   s_addr,   (busy == 2) ? cur_t.addr : 16'h0);
      check_val("s_wdata",  s_wdata,  (busy == 2) ? cur_t.data : 16'h0);
      check_val("bus_err",  bus_err,  busy == 1 && exp_err);
      check_val("m0_rdata", m0_rdata, exp_rd[0]);
      check_val("m1_rdata", m1_rdata, exp_rd[1]);
      if (m0_ack) acks.push_back(0);
      if (m1_ack) acks.push_back(1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      q0.delete();
      q1.delete();
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic check_order(input string tag, input int exp_seq[$]);
      check_val({tag, "_count"}, acks.size(), exp_seq.size());
      for (int i = 0; i < exp_seq.size() && i < acks.size(); i++)
         check_val($sformatf("%s_%0d", tag, i), acks[i], exp_seq[i]);
   endtask

   initial begin
      int seq[$];
      bit hit;
      rst_n = 1'b0;
      m0_req = 0; m0_lock = 0; m0_write = 0; m0_addr = '0; m0_wdata = '0;
      m1_req = 0; m1_lock = 0; m1_write = 0; m1_addr = '0; m1_wdata = '0;
      s_rdata_io = '0; s_rdata_ram = '0;
      exp_rd[0] = '0; exp_rd[1] = '0;
      cur_t = '0;

      // single read from RAM region
      do_reset();
      rd_fix = 1; s_rdata_ram = 16'hBEEF; s_rdata_io = 16'h1111;
      q0.push_back(mk(1'b0, 16'h4010, 16'h0, 1'b0, 1'b0));
      repeat (5) step();
      check_val("ram_read_data", m0_rdata, 16'hBEEF);
      rd_fix = 0;

      // simultaneous requests after reset: m0 first, then alternate
      do_reset(); acks.delete();
      repeat (2) begin
         q0.push_back(mk(1'b0, 16'h0100, 16'h0, 1'b0, 1'b0));
         q1.push_back(mk(1'b0, 16'h4200, 16'h0, 1'b0, 1'b0));
      end
      repeat (16) step();
      seq = '{0, 1, 0, 1};
      check_order("tie_order", seq);

      // m1 locked burst of 12 writes against a continuously requesting m0
      do_reset(); acks.delete();
      for (int i = 0; i < 12; i++)
         q1.push_back(mk(1'b1, 16'h4000 + 16'(i), 16'(16'hA000 + i), i != 11, 1'b0));
      step();
      for (int i = 0; i < 4; i++)
         q0.push_back(mk(1'b0, 16'h0040 + 16'(i), 16'h0, 1'b0, 1'b0));
      repeat (60) step();
      seq = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 0, 0};
      check_order("burst_order", seq);

      // unmapped regions: write to region 2, read from region 3
      do_reset();
      q0.push_back(mk(1'b0, 16'h4004, 16'h0, 1'b0, 1'b0));
      q0.push_back(mk(1'b1, 16'h8000, 16'h1234, 1'b0, 1'b0));
      q0.push_back(mk(1'b0, 16'hC000, 16'h0, 1'b0, 1'b0));
      repeat (12) step();
      check_val("unmapped_rdata", m0_rdata, 16'h0000);

      // random traffic with locks and dropped requests
      do_reset();
      for (int c = 0; c < 400; c++) begin
         if (q0.size() < 3 && $urandom_range(3) == 0)
            q0.push_back(mk(1'($urandom), 16'($urandom), 16'($urandom),
                            1'($urandom), $urandom_range(7) == 0));
         if (q1.size() < 3 && $urandom_range(3) == 0)
            q1.push_back(mk(1'($urandom), 16'($urandom), 16'($urandom),
                            1'($urandom), $urandom_range(7) == 0));
         step();
      end
      repeat (40) step();

      // reset asserted during m1 write access
      acks.delete();
      q1.push_back(mk(1'b1, 16'h4444, 16'h5A5A, 1'b0, 1'b0));
      hit = 0;
      for (int i = 0; i < 10 && !hit; i++) begin
         step();
         hit = (busy == 2);
      end
      check_val("reach_access", hit, 1'b1);
      rst_n = 1'b0;
      q0.delete();
      q1.delete();
      step();
      check_val("rst_no_ack", m1_ack, 1'b0);
      check_val("rst_no_write", s_write, 1'b0);
      rst_n = 1'b1;
      repeat (3) step();
      check_val("rst_ack_count", acks.size(), 0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
